// File: rtl/axi_lite_ram_slave.sv
// AXI-lite single-port RAM target with one decoded address window.
// Independent read and write channel FSMs, byte-strobed writes,
// configurable read latency, SLVERR on out-of-window accesses.
module axi_lite_ram_slave #(
    parameter int unsigned                AXI_ADDR_WIDTH = 64,
    parameter int unsigned                AXI_DATA_WIDTH = 64,
    parameter logic [AXI_ADDR_WIDTH-1:0]  MEM_BEGIN      = 64'h80000000,
    parameter int unsigned                MEM_WORDS      = 4096,
    parameter int unsigned                READ_LATENCY   = 1,
    parameter int unsigned                PORT_WIDTH     = 2
) (
    input  logic                          clk,
    input  logic                          rstn,
    // write address / data / response
    input  logic [AXI_ADDR_WIDTH-1:0]     awaddr_i,
    input  logic [PORT_WIDTH-1:0]         awport_i,
    input  logic                          awvalid_i,
    output logic                          awready_o,
    input  logic [AXI_DATA_WIDTH-1:0]     wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0]   wstrb_i,
    input  logic                          wvalid_i,
    output logic                          wready_o,
    output logic [1:0]                    bresp_o,
    output logic                          bvalid_o,
    input  logic                          bready_i,
    // read address / data
    input  logic [AXI_ADDR_WIDTH-1:0]     araddr_i,
    input  logic [PORT_WIDTH-1:0]         arport_i,
    input  logic                          arvalid_i,
    output logic                          arready_o,
    output logic [AXI_DATA_WIDTH-1:0]     rdata_o,
    output logic [1:0]                    rresp_o,
    output logic                          rvalid_o,
    input  logic                          rready_i
);

    localparam int unsigned NB    = AXI_DATA_WIDTH / 8;
    localparam int unsigned LSB   = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W = 4;
    localparam logic [AXI_ADDR_WIDTH-1:0] MEM_END =
        MEM_BEGIN + AXI_ADDR_WIDTH'(MEM_WORDS) * AXI_ADDR_WIDTH'(NB);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_COMMIT = 2'd1,
        W_RESP   = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    w_state_e                  w_state_q;
    logic                      aw_held_q, w_held_q;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [NB-1:0]             wstrb_q;
    logic                      awready_q, wready_q, bvalid_q;
    logic [1:0]                bresp_q;

    r_state_e                  r_state_q;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      arready_q, rvalid_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                rresp_q;

    logic                      aw_fire, w_fire, ar_fire;
    logic                      w_hit, r_hit;
    logic [AXI_ADDR_WIDTH-1:0] w_off, r_off;
    logic [IDX_W-1:0]          w_idx, r_idx;
    logic                      unused_ok;

    // Handshakes and window decode of the latched addresses
    assign aw_fire = awvalid_i && awready_q;
    assign w_fire  = wvalid_i && wready_q;
    assign ar_fire = arvalid_i && arready_q;

    assign w_hit = (awaddr_q >= MEM_BEGIN) && (awaddr_q < MEM_END);
    assign r_hit = (araddr_q >= MEM_BEGIN) && (araddr_q < MEM_END);
    assign w_off = awaddr_q - MEM_BEGIN;
    assign r_off = araddr_q - MEM_BEGIN;
    assign w_idx = w_off[LSB +: IDX_W];
    assign r_idx = r_off[LSB +: IDX_W];

    // Port ids and the byte-offset / high offset bits carry no meaning here
    assign unused_ok = ^{awport_i, arport_i, w_off, r_off};

    // Write channel FSM: collect AW and W in any order, commit, respond
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_fire) begin
                        awaddr_q  <= awaddr_i;
                        aw_held_q <= 1'b1;
                    end
                    if (w_fire) begin
                        wdata_q  <= wdata_i;
                        wstrb_q  <= wstrb_i;
                        w_held_q <= 1'b1;
                    end
                    awready_q <= !(aw_held_q || aw_fire);
                    wready_q  <= !(w_held_q || w_fire);
                    if (aw_held_q && w_held_q) begin
                        w_state_q <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    bresp_q   <= w_hit ? RESP_OKAY : RESP_SLVERR;
                    aw_held_q <= 1'b0;
                    w_held_q  <= 1'b0;
                    bvalid_q  <= 1'b1;
                    w_state_q <= W_RESP;
                end
                W_RESP: begin
                    if (bready_i) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    aw_held_q <= 1'b0;
                    w_held_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                    awready_q <= 1'b1;
                    wready_q  <= 1'b1;
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Byte-strobed memory write on the edge that ends W_COMMIT
    always_ff @(posedge clk) begin
        if (w_state_q == W_COMMIT && w_hit) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (wstrb_q[b]) begin
                    mem[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    // Read channel FSM: accept AR, count latency, sample memory, hold R
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q <= R_IDLE;
            araddr_q  <= '0;
            cnt_q     <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_fire) begin
                        araddr_q  <= araddr_i;
                        cnt_q     <= CNT_W'(READ_LATENCY - 1);
                        arready_q <= 1'b0;
                        r_state_q <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        // Sampled alongside a same-edge commit, this returns the old word
                        rdata_q   <= r_hit ? mem[r_idx] : '0;
                        rresp_q   <= r_hit ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rready_i) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: begin
                    rvalid_q  <= 1'b0;
                    arready_q <= 1'b1;
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign awready_o = awready_q;
    assign wready_o  = wready_q;
    assign bvalid_o  = bvalid_q;
    assign bresp_o   = bresp_q;
    assign arready_o = arready_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rresp_o   = rresp_q;

endmodule
